// File: rtl/data_access_pkg.sv
// Shared types and constants for the memory-stage data-bus controller.
package data_access_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StDrain
  } dacc_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/data_access_load_ext.sv
// Load lane select and sign/zero extension of a bus read word.
module data_access_load_ext
  import data_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_rdata[{i_addr, 3'b000} +: 8];
    w_half   = i_rdata[{i_addr[1], 4'b0000} +: 16];
    o_result = i_rdata;
    case (i_size)
      SIZE_BYTE: o_result = {{24{i_sign & w_byte[7]}}, w_byte};
      SIZE_HALF: o_result = {{16{i_sign & w_half[15]}}, w_half};
      default:   o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/data_access.sv
// Memory-stage load/store controller: drives the SRAM-like data bus, stalls the
// pipeline until the access completes and returns the extended load result.
module data_access
  import data_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_kill,
  input  logic        pipe_advance,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall_reqM,
  output logic [31:0] load_result,
  output logic        result_valid
);

  dacc_state_t r_state, w_state_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_result;

  logic        w_capture;
  logic        w_load_result;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_ext;

  always_comb begin
    case (req_size)
      SIZE_BYTE: w_wdata_rep = {4{req_wdata[7:0]}};
      SIZE_HALF: w_wdata_rep = {2{req_wdata[15:0]}};
      default:   w_wdata_rep = req_wdata;
    endcase
  end

  data_access_load_ext u_load_ext (
    .i_rdata  (data_rdata),
    .i_addr   (r_addr[1:0]),
    .i_size   (r_size),
    .i_sign   (r_sign),
    .o_result (w_ext)
  );

  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    w_load_result = 1'b0;
    case (r_state)
      StIdle: begin
        if (req_valid && !req_kill) begin
          w_capture    = 1'b1;
          w_state_next = StReq;
        end
      end
      StReq: begin
        if (req_kill)          w_state_next = StIdle;
        else if (data_addr_ok) w_state_next = StWait;
      end
      StWait: begin
        // A kill that coincides with completion just drops the data.
        if (data_ok) begin
          if (req_kill) begin
            w_state_next = StIdle;
          end else begin
            w_load_result = 1'b1;
            w_state_next  = StDone;
          end
        end else if (req_kill) begin
          w_state_next = StDrain;
        end
      end
      StDone: begin
        if (pipe_advance || req_kill) w_state_next = StIdle;
      end
      StDrain: begin
        if (data_ok) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_we     <= 1'b0;
      r_size   <= 2'd0;
      r_sign   <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_sign  <= req_sign;
        r_addr  <= req_addr;
        r_wdata <= w_wdata_rep;
      end
      if (w_load_result) r_result <= r_we ? 32'd0 : w_ext;
    end
  end

  assign data_req     = (r_state == StReq) && !req_kill;
  assign data_wr      = r_we;
  assign data_size    = r_size;
  assign data_addr    = r_addr;
  assign data_wdata   = r_wdata;
  assign load_result  = r_result;
  assign result_valid = (r_state == StDone);

  assign stall_reqM = ((r_state == StIdle) && req_valid && !req_kill) ||
                      (r_state == StReq) || (r_state == StWait) ||
                      ((r_state == StDrain) && req_valid);

endmodule
